memory: RTL and testbench

Memory-access stage of the five-stage pipeline, between execute and writeback. Consumes the execute-stage register bundle, performs loads/stores over the data bus with a valid/data_ok handshake, sign/zero-extends load data, and registers the memory-stage bundle for writeback. Back-pressures execute with `stopm` while a bus transaction is outstanding. Drains a transaction already on the bus correctly when the stage is flushed.

---
 rtl/memory_pkg.sv | 66 ++++++
 rtl/memory_memalign.sv | 43 ++++
 rtl/memory.sv | 113 +++++++++++
 tb/tb_memory.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared types for the memory-access stage: execute/memory bundles, data-bus
// request/response, access sizes and error codes.
package memory_pkg;

  typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;
  typedef enum logic [1:0] {OP_ALU, OP_LOAD, OP_STORE, OP_CSR} op_t;
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} mstate_t;

  localparam logic [3:0] ERR_NONE     = 4'd0;
  localparam logic [3:0] ERR_MISALIGN = 4'd4;

  typedef struct packed {
    op_t        op;
    msize_t     msize;
    logic       msign;
    logic       regwrite;
  } ctl_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
    ctl_t        ctl;
    logic [4:0]  dst;
    logic [63:0] rd2;
    logic [63:0] result;
    logic [63:0] csr;
    logic [11:0] csrdst;
    logic [3:0]  error;
  } excute_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
    ctl_t        ctl;
    logic [4:0]  dst;
    logic [63:0] result;
    logic [63:0] csr;
    logic [11:0] csrdst;
    logic [3:0]  error;
  } memory_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  function automatic logic [7:0] size_mask(msize_t s);
    case (s)
      MSIZE1:  return 8'h01;
      MSIZE2:  return 8'h03;
      MSIZE4:  return 8'h0f;
      default: return 8'hff;
    endcase
  endfunction

endpackage

// File: rtl/memory_memalign.sv
// Byte-lane steering for the data bus: store strobe/data placement, alignment
// check, and load lane extraction with sign/zero extension.
module memalign
  import memory_pkg::*;
(
  input  logic [2:0]  addr,
  input  msize_t      size,
  input  logic        sign,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  strobe,
  output logic [63:0] wdata_sh,
  output logic        misalign,
  output logic [63:0] rdata_ext
);

  logic [5:0]  bit_off;
  logic [63:0] lane;

  assign bit_off  = {addr, 3'b000};
  assign strobe   = size_mask(size) << addr;
  assign wdata_sh = wdata << bit_off;
  assign lane     = rdata >> bit_off;

  always_comb begin
    case (size)
      MSIZE1:  misalign = 1'b0;
      MSIZE2:  misalign = addr[0];
      MSIZE4:  misalign = |addr[1:0];
      default: misalign = |addr;
    endcase
  end

  always_comb begin
    case (size)
      MSIZE1:  rdata_ext = sign ? {{56{lane[7]}},  lane[7:0]}  : {56'b0, lane[7:0]};
      MSIZE2:  rdata_ext = sign ? {{48{lane[15]}}, lane[15:0]} : {48'b0, lane[15:0]};
      MSIZE4:  rdata_ext = sign ? {{32{lane[31]}}, lane[31:0]} : {32'b0, lane[31:0]};
      default: rdata_ext = lane;
    endcase
  end

endmodule

// File: rtl/memory.sv
// Memory-access stage: issues loads/stores on the data bus, stalls execute
// while a transaction is outstanding, and registers the bundle for writeback.
module memory
  import memory_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flushem,
  input  excute_data_t dataE,
  output dbus_req_t    dreq,
  input  dbus_resp_t   dresp,
  output memory_data_t dataM,
  output logic         stopm
);

  mstate_t      state;
  dbus_req_t    req_q;
  logic         req_sign;
  memory_data_t m_next;

  logic         is_mem, is_load, is_store, issue, done, bad;
  logic [2:0]   a_addr;
  msize_t       a_size;
  logic         a_sign;
  logic [7:0]   strobe;
  logic [63:0]  wdata_sh, rdata_ext;
  logic         misalign;

  assign is_load  = dataE.valid && (dataE.ctl.op == OP_LOAD);
  assign is_store = dataE.valid && (dataE.ctl.op == OP_STORE);
  assign is_mem   = is_load || is_store;

  // Outside IDLE the in-flight request owns the lane logic so load data is
  // extracted with the address/size that actually went out on the bus.
  assign a_addr = (state == IDLE) ? dataE.result[2:0] : req_q.addr[2:0];
  assign a_size = (state == IDLE) ? dataE.ctl.msize   : req_q.size;
  assign a_sign = (state == IDLE) ? dataE.ctl.msign   : req_sign;

  memalign u_align (
    .addr      (a_addr),
    .size      (a_size),
    .sign      (a_sign),
    .wdata     (dataE.rd2),
    .rdata     (dresp.data),
    .strobe    (strobe),
    .wdata_sh  (wdata_sh),
    .misalign  (misalign),
    .rdata_ext (rdata_ext)
  );

  // Gating with reset keeps the bus quiet while the core is held in reset.
  assign bad   = (state == IDLE) && is_mem && misalign;
  assign issue = reset && (state == IDLE) && is_mem && !misalign;
  assign done  = dresp.data_ok && (issue || state == WAIT);
  assign stopm = (issue && !dresp.data_ok)
              || (state == WAIT && !dresp.data_ok)
              || (state == DRAIN && is_mem);

  always_comb begin
    dreq = req_q;
    if (state == IDLE) begin
      dreq = '0;
      if (issue) begin
        dreq.valid  = 1'b1;
        dreq.addr   = dataE.result;
        dreq.size   = dataE.ctl.msize;
        dreq.strobe = is_store ? strobe   : 8'h00;
        dreq.data   = is_store ? wdata_sh : 64'h0;
      end
    end
  end

  always_comb begin
    m_next        = '0;
    m_next.valid  = dataE.valid;
    m_next.pc     = dataE.pc;
    m_next.instr  = dataE.instr;
    m_next.ctl    = dataE.ctl;
    m_next.dst    = dataE.dst;
    m_next.csr    = dataE.csr;
    m_next.csrdst = dataE.csrdst;
    m_next.result = (is_load && done) ? rdata_ext : dataE.result;
    if (dataE.error != ERR_NONE) m_next.error = dataE.error;
    else if (bad)                m_next.error = ERR_MISALIGN;
    else                         m_next.error = ERR_NONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      req_q    <= '0;
      req_sign <= 1'b0;
      dataM    <= '0;
    end else begin
      case (state)
        IDLE: if (issue) begin
          req_q    <= dreq;
          req_sign <= dataE.ctl.msign;
          if (!dresp.data_ok) state <= flushem ? DRAIN : WAIT;
        end
        WAIT: begin
          if (dresp.data_ok) state <= IDLE;
          else if (flushem)  state <= DRAIN;
        end
        DRAIN: if (dresp.data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (!stopm)  dataM       <= m_next;
      if (flushem) dataM.valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory.sv
// Directed bench for the memory stage: waits, lane extraction, stores,
// misalignment, flush/drain and asynchronous reset.
module tb_memory;
  import memory_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         flushem;
  excute_data_t dataE;
  dbus_req_t    dreq;
  dbus_resp_t   dresp;
  memory_data_t dataM;
  logic         stopm;
  int           vecs = 0;
  int           errs = 0;

  memory dut (
    .clk     (clk),
    .reset   (reset),
    .flushem (flushem),
    .dataE   (dataE),
    .dreq    (dreq),
    .dresp   (dresp),
    .dataM   (dataM),
    .stopm   (stopm)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic excute_data_t mk(op_t op, msize_t sz, logic sg,
                                      logic [63:0] addr, logic [63:0] rd2);
    excute_data_t d;
    d              = '0;
    d.valid        = 1'b1;
    d.pc           = 64'h0000_0000_8000_1000;
    d.instr        = 32'h0000_0013;
    d.ctl.op       = op;
    d.ctl.msize    = sz;
    d.ctl.msign    = sg;
    d.ctl.regwrite = (op != OP_STORE);
    d.dst          = 5'd10;
    d.rd2          = rd2;
    d.result       = addr;
    return d;
  endfunction

  task automatic test_reset();
    #2;
    vecs++;
    if (dataM !== '0) begin errs++; $display("FAIL reset_dataM got %h want 0", dataM); end
    vecs++;
    if (dreq.valid !== 1'b0) begin errs++; $display("FAIL reset_dreq_valid got %b want 0", dreq.valid); end
    vecs++;
    if (stopm !== 1'b0) begin errs++; $display("FAIL reset_stopm got %b want 0", stopm); end
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_ld_wait();
    int high = 0;
    dataE = mk(OP_LOAD, MSIZE8, 1'b1, 64'h8000_0010, 64'h0);
    dresp = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stopm === 1'b1) high++;
      vecs++;
      if (dreq.valid !== 1'b1 || dreq.addr !== 64'h8000_0010 || dreq.strobe !== 8'h00)
        begin errs++; $display("FAIL ld_req_%0d got v=%b a=%h s=%h want v=1 a=80000010 s=00", i, dreq.valid, dreq.addr, dreq.strobe); end
      tick();
    end
    dresp.data_ok = 1'b1;
    dresp.data    = 64'h1122_3344_5566_7788;
    #1;
    vecs++;
    if (stopm !== 1'b0) begin errs++; $display("FAIL ld_stopm_done got %b want 0", stopm); end
    vecs++;
    if (high != 3) begin errs++; $display("FAIL ld_stall_cycles got %0d want 3", high); end
    tick();
    dresp = '0;
    dataE = '0;
    vecs++;
    if (dataM.valid !== 1'b1 || dataM.result !== 64'h1122_3344_5566_7788)
      begin errs++; $display("FAIL ld_result got v=%b r=%h want v=1 r=1122334455667788", dataM.valid, dataM.result); end
  endtask

  task automatic test_back_to_back();
    dataE = mk(OP_LOAD, MSIZE1, 1'b1, 64'h8000_0013, 64'h0);
    dresp.data_ok = 1'b1;
    dresp.data    = 64'h0000_0000_8000_0000;
    #1;
    vecs++;
    if (stopm !== 1'b0 || dreq.size !== MSIZE1)
      begin errs++; $display("FAIL lb_req got stopm=%b size=%0d want stopm=0 size=0", stopm, dreq.size); end
    tick();
    vecs++;
    if (dataM.result !== 64'hFFFF_FFFF_FFFF_FF80 || dataM.valid !== 1'b1)
      begin errs++; $display("FAIL lb_result got v=%b r=%h want v=1 r=ffffffffffffff80", dataM.valid, dataM.result); end
    dataE = mk(OP_LOAD, MSIZE1, 1'b0, 64'h8000_0013, 64'h0);
    tick();
    vecs++;
    if (dataM.result !== 64'h0000_0000_0000_0080)
      begin errs++; $display("FAIL lbu_result got %h want 0000000000000080", dataM.result); end
    dresp = '0;
    dataE = '0;
  endtask

  task automatic test_store();
    dataE = mk(OP_STORE, MSIZE2, 1'b0, 64'h8000_0006, 64'h0000_0000_0000_ABCD);
    dresp.data_ok = 1'b1;
    #1;
    vecs++;
    if (dreq.valid !== 1'b1 || dreq.strobe !== 8'hC0)
      begin errs++; $display("FAIL sh_strobe got v=%b s=%h want v=1 s=c0", dreq.valid, dreq.strobe); end
    vecs++;
    if (dreq.data[63:48] !== 16'hABCD)
      begin errs++; $display("FAIL sh_data got %h want abcd", dreq.data[63:48]); end
    vecs++;
    if (stopm !== 1'b0) begin errs++; $display("FAIL sh_stopm got %b want 0", stopm); end
    tick();
    dresp = '0;
    dataE = '0;
    vecs++;
    if (dataM.valid !== 1'b1 || dataM.result !== 64'h8000_0006 || dataM.error !== ERR_NONE)
      begin errs++; $display("FAIL sh_dataM got v=%b r=%h e=%h want v=1 r=80000006 e=0", dataM.valid, dataM.result, dataM.error); end
  endtask

  task automatic test_misalign();
    dataE = mk(OP_LOAD, MSIZE4, 1'b1, 64'h8000_0002, 64'h0);
    #1;
    vecs++;
    if (dreq.valid !== 1'b0 || stopm !== 1'b0)
      begin errs++; $display("FAIL lw_mis_bus got v=%b stopm=%b want 0 0", dreq.valid, stopm); end
    tick();
    vecs++;
    if (dataM.valid !== 1'b1 || dataM.error !== ERR_MISALIGN || dataM.result !== 64'h8000_0002)
      begin errs++; $display("FAIL lw_mis_err got v=%b e=%h r=%h want v=1 e=4 r=80000002", dataM.valid, dataM.error, dataM.result); end
    dataE       = mk(OP_ALU, MSIZE8, 1'b0, 64'h0000_0000_0000_1234, 64'h0);
    dataE.error = 4'd2;
    tick();
    vecs++;
    if (dataM.error !== 4'd2 || dataM.result !== 64'h1234)
      begin errs++; $display("FAIL alu_err_pass got e=%h r=%h want e=2 r=1234", dataM.error, dataM.result); end
    dataE = '0;
  endtask

  task automatic test_flush_drain();
    dataE = mk(OP_LOAD, MSIZE8, 1'b1, 64'h8000_0020, 64'h0);
    dresp = '0;
    tick();
    flushem = 1'b1;
    #1;
    vecs++;
    if (stopm !== 1'b1) begin errs++; $display("FAIL flush_wait_stopm got %b want 1", stopm); end
    tick();
    flushem = 1'b0;
    vecs++;
    if (dataM.valid !== 1'b0) begin errs++; $display("FAIL flush_valid got %b want 0", dataM.valid); end
    dataE = mk(OP_LOAD, MSIZE8, 1'b1, 64'h8000_0028, 64'h0);
    #1;
    vecs++;
    if (dreq.valid !== 1'b1 || dreq.addr !== 64'h8000_0020 || stopm !== 1'b1)
      begin errs++; $display("FAIL drain_hold got v=%b a=%h stopm=%b want v=1 a=80000020 stopm=1", dreq.valid, dreq.addr, stopm); end
    tick();
    dresp.data_ok = 1'b1;
    dresp.data    = 64'hDEAD_DEAD_DEAD_DEAD;
    #1;
    vecs++;
    if (dreq.addr !== 64'h8000_0020 || stopm !== 1'b1)
      begin errs++; $display("FAIL drain_done got a=%h stopm=%b want a=80000020 stopm=1", dreq.addr, stopm); end
    tick();
    dresp = '0;
    vecs++;
    if (dataM.valid !== 1'b0) begin errs++; $display("FAIL drain_discard got %b want 0", dataM.valid); end
    #1;
    vecs++;
    if (dreq.valid !== 1'b1 || dreq.addr !== 64'h8000_0028)
      begin errs++; $display("FAIL post_drain_issue got v=%b a=%h want v=1 a=80000028", dreq.valid, dreq.addr); end
    dresp.data_ok = 1'b1;
    dresp.data    = 64'hCAFE_F00D_1234_5678;
    tick();
    dresp = '0;
    dataE = '0;
    vecs++;
    if (dataM.valid !== 1'b1 || dataM.result !== 64'hCAFE_F00D_1234_5678)
      begin errs++; $display("FAIL post_drain_result got v=%b r=%h want v=1 r=cafef00d12345678", dataM.valid, dataM.result); end
  endtask

  task automatic test_reset_mid();
    dataE = mk(OP_LOAD, MSIZE8, 1'b0, 64'h8000_0030, 64'h0);
    dresp = '0;
    tick();
    #2 reset = 1'b0;
    #1;
    vecs++;
    if (dataM !== '0 || dreq.valid !== 1'b0 || stopm !== 1'b0)
      begin errs++; $display("FAIL async_reset got m=%h v=%b stopm=%b want 0 0 0", dataM, dreq.valid, stopm); end
    tick();
    reset = 1'b1;
    #1;
    vecs++;
    if (dreq.valid !== 1'b1 || dreq.addr !== 64'h8000_0030 || stopm !== 1'b1)
      begin errs++; $display("FAIL reset_idle_issue got v=%b a=%h stopm=%b want v=1 a=80000030 stopm=1", dreq.valid, dreq.addr, stopm); end
    dresp.data_ok = 1'b1;
    dresp.data    = 64'h0102_0304_0506_0708;
    tick();
    dresp = '0;
    dataE = '0;
    vecs++;
    if (dataM.valid !== 1'b1 || dataM.result !== 64'h0102_0304_0506_0708)
      begin errs++; $display("FAIL reset_recover got v=%b r=%h want v=1 r=0102030405060708", dataM.valid, dataM.result); end
  endtask

  initial begin
    reset   = 1'b0;
    flushem = 1'b0;
    dataE   = '0;
    dresp   = '0;
    test_reset();
    test_ld_wait();
    test_back_to_back();
    test_store();
    test_misalign();
    test_flush_drain();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
